sync_fifo_ctrl: RTL and testbench

//  Single-clock FIFO, next generation of the async FIFO for same-domain buffering.

---
 rtl/sync_fifo_ctrl_if.sv | 42 ++++
 rtl/sync_fifo_ctrl.sv | 93 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
// Error flag signals exist only when SYNC_FIFO_ERR_EN is defined.
interface sync_fifo_ctrl_if #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 8
);
    logic                  wr_en;
    logic [Data_Width-1:0] data_in;
    logic                  rd_en;
    logic [Data_Width-1:0] data_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [Addr_Width:0]   fill_level;
`ifdef SYNC_FIFO_ERR_EN
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;
`endif

    // Producer/consumer side
    modport master (
        output wr_en, data_in, rd_en,
`ifdef SYNC_FIFO_ERR_EN
        output err_clr,
        input  overflow, underflow,
`endif
        input  data_out, rd_valid, full, empty, almost_full, almost_empty, fill_level
    );

    // FIFO side
    modport slave (
        input  wr_en, data_in, rd_en,
`ifdef SYNC_FIFO_ERR_EN
        input  err_clr,
        output overflow, underflow,
`endif
        output data_out, rd_valid, full, empty, almost_full, almost_empty, fill_level
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill level and programmable almost-full/almost-empty flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_ctrl #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 8,
    parameter int Depth      = 256,
    parameter int AF_Thresh  = 252,
    parameter int AE_Thresh  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    sync_fifo_ctrl_if.slave       bus
);
    localparam int PtrW = Addr_Width + 1;

    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [Data_Width-1:0] r_mem [Depth];
    logic [Data_Width-1:0] r_data_out;
    logic                  r_rd_valid;

    logic [PtrW-1:0]       w_fill;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Extra pointer MSB distinguishes full from empty when the low bits match
    assign w_fill   = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_fill == PtrW'(Depth));
    assign w_empty  = (w_fill == '0);
    assign w_wr_acc = bus.wr_en && !w_full;
    assign w_rd_acc = bus.rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[Addr_Width-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr[Addr_Width-1:0]];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.fill_level   = w_fill;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (w_fill >= PtrW'(AF_Thresh));
    assign bus.almost_empty = (w_fill <= PtrW'(AE_Thresh));

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised and directed bench for sync_fifo_ctrl against a queue-based reference model.
module tb_sync_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk;
    logic rstn;

    sync_fifo_ctrl_if #(.Data_Width(DW), .Addr_Width(AW)) fif ();

    sync_fifo_ctrl #(
        .Data_Width(DW), .Addr_Width(AW), .Depth(DEPTH),
        .AF_Thresh(AF), .AE_Thresh(AE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all();
        chk("fill_level",   32'(fif.fill_level),   32'(m_q.size()));
        chk("full",         32'(fif.full),         32'(m_q.size() == DEPTH));
        chk("empty",        32'(fif.empty),        32'(m_q.size() == 0));
        chk("almost_full",  32'(fif.almost_full),  32'(m_q.size() >= AF));
        chk("almost_empty", 32'(fif.almost_empty), 32'(m_q.size() <= AE));
        chk("rd_valid",     32'(fif.rd_valid),     32'(m_valid));
        chk("data_out",     32'(fif.data_out),     32'(m_dout));
`ifdef SYNC_FIFO_ERR_EN
        chk("overflow",     32'(fif.overflow),     32'(m_ovf));
        chk("underflow",    32'(fif.underflow),    32'(m_unf));
`endif
    endtask

    // One clock: drive, step the model on the edge using pre-edge occupancy, then check
    task automatic cycle(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
        int  pre;
        logic rd_ok;
        logic wr_ok;
        fif.wr_en   = wr;
        fif.data_in = din;
        fif.rd_en   = rd;
`ifdef SYNC_FIFO_ERR_EN
        fif.err_clr = clr;
`endif
        @(posedge clk);
        pre   = m_q.size();
        rd_ok = rd && (pre > 0);
        wr_ok = wr && (pre < DEPTH);
        if (wr && pre == DEPTH)  m_ovf = 1'b1;
        else if (clr)            m_ovf = 1'b0;
        if (rd && pre == 0)      m_unf = 1'b1;
        else if (clr)            m_unf = 1'b0;
        m_valid = rd_ok;
        if (rd_ok) m_dout = m_q.pop_front();
        if (wr_ok) m_q.push_back(din);
        #1;
        check_all();
        $display("cyc wr=%0b din=%02h rd=%0b -> lvl=%0d valid=%0b dout=%02h",
                 wr, din, rd, fif.fill_level, fif.rd_valid, fif.data_out);
    endtask

    initial begin
        rstn        = 1'b0;
        fif.wr_en   = 1'b0;
        fif.data_in = '0;
        fif.rd_en   = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        fif.err_clr = 1'b0;
`endif
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rstn = 1'b1;

        // Fill 0x01..0x08, then read back in order
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Write while full is dropped; flag then cleared
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous request on empty: write only
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Hold level 4 through 20 concurrent cycles (pointers wrap)
        for (int i = 0; i < 4; i++)  cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);

        // Randomised traffic, write-biased then read-biased
        for (int i = 0; i < 400; i++) begin
            int pw;
            pw = (i < 200) ? 70 : 30;
            cycle(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < (100 - pw)),
                  ($urandom_range(0, 19) == 0));
        end

        // Async reset with a read pending at level 5
        while (m_q.size() < 5) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        while (m_q.size() > 5) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b1;
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
